// File: rtl/ysyx_22050019_axi_sram_slave.sv
// rtl/ysyx_22050019_axi_sram_slave.sv - AXI4-lite-style SRAM slave with independent read/write FSMs
// Optional: define AXI_SRAM_LFSR_DELAY_EN to add 0..3 pseudo-random extra wait cycles per response.
module ysyx_22050019_axi_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LAT     = 1,
  parameter int                    WR_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     aw_addr,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic [DATA_WIDTH/8-1:0]   w_strb,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [1:0]                b_resp,
  output logic                      b_valid,
  input  logic                      b_ready,
  input  logic [ADDR_WIDTH-1:0]     ar_addr,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [DATA_WIDTH-1:0]     r_data,
  output logic [1:0]                r_resp,
  output logic                      r_valid,
  input  logic                      r_ready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = 8;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_WAIT, WS_RESP} ws_t;
  typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_RESP} rs_t;

  ws_t ws, ws_nxt;
  rs_t rs, rs_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [CNT_W-1:0]      wr_cnt, rd_cnt, wr_load, rd_load;
  logic [IDX_W-1:0]      wr_idx, rd_idx, aw_idx, ar_idx, rd_sel_idx;
  logic                  wr_err, rd_err, aw_err, ar_err, rd_sel_err;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  aw_fire, w_fire, ar_fire, rd_enter_resp;

  // Address decode: out-of-window addresses below or above the array give DECERR
  assign aw_off = aw_addr - BASE_ADDR;
  assign ar_off = ar_addr - BASE_ADDR;
  assign aw_err = (aw_addr < BASE_ADDR) || ((aw_off >> OFF_W) >= DEPTH_A);
  assign ar_err = (ar_addr < BASE_ADDR) || ((ar_off >> OFF_W) >= DEPTH_A);
  assign aw_idx = aw_off[OFF_W +: IDX_W];
  assign ar_idx = ar_off[OFF_W +: IDX_W];

  assign aw_fire = (ws == WS_IDLE) && aw_valid;
  assign w_fire  = (ws == WS_DATA) && w_valid;
  assign ar_fire = (rs == RS_IDLE) && ar_valid;

`ifdef AXI_SRAM_LFSR_DELAY_EN
  logic [7:0] lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying jitter for the response latency
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign wr_load = CNT_W'(WR_LAT) + CNT_W'(lfsr[1:0]);
  assign rd_load = CNT_W'(RD_LAT) + CNT_W'(lfsr[1:0]);
`else
  assign wr_load = CNT_W'(WR_LAT);
  assign rd_load = CNT_W'(RD_LAT);
`endif

  // State registers for both channels
  always_ff @(posedge clk) begin
    if (rst) begin
      ws <= WS_IDLE;
      rs <= RS_IDLE;
    end else begin
      ws <= ws_nxt;
      rs <= rs_nxt;
    end
  end

  // Write FSM next state; readies/valid come from state only
  always_comb begin
    ws_nxt   = ws;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (ws)
      WS_IDLE: begin
        aw_ready = 1'b1;
        if (aw_valid) ws_nxt = WS_DATA;
      end
      WS_DATA: begin
        w_ready = 1'b1;
        if (w_valid) ws_nxt = (wr_load == '0) ? WS_RESP : WS_WAIT;
      end
      WS_WAIT: if (wr_cnt <= CNT_W'(1)) ws_nxt = WS_RESP;
      WS_RESP: begin
        b_valid = 1'b1;
        if (b_ready) ws_nxt = WS_IDLE;
      end
      default: ws_nxt = WS_IDLE;
    endcase
  end

  // Read FSM next state; readies/valid come from state only
  always_comb begin
    rs_nxt   = rs;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (rs)
      RS_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) rs_nxt = (rd_load == '0) ? RS_RESP : RS_WAIT;
      end
      RS_WAIT: if (rd_cnt <= CNT_W'(1)) rs_nxt = RS_RESP;
      RS_RESP: begin
        r_valid = 1'b1;
        if (r_ready) rs_nxt = RS_IDLE;
      end
      default: rs_nxt = RS_IDLE;
    endcase
  end

  // Write channel context: latched address, latency counter, response code
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      wr_err <= 1'b0;
      wr_cnt <= '0;
      b_resp <= 2'b00;
    end else begin
      if (aw_fire) begin
        wr_idx <= aw_idx;
        wr_err <= aw_err;
      end
      if (w_fire) begin
        wr_cnt <= wr_load;
        b_resp <= wr_err ? 2'b11 : 2'b00;
      end else if (ws == WS_WAIT && wr_cnt != '0) begin
        wr_cnt <= wr_cnt - CNT_W'(1);
      end
    end
  end

  // Byte-strobe commit on the W handshake; array is never reset
  always_ff @(posedge clk) begin
    if (!rst && w_fire && !wr_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[wr_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // Read word with forwarding of a same-cycle write to the same index
  assign rd_sel_idx    = (rs == RS_IDLE) ? ar_idx : rd_idx;
  assign rd_sel_err    = (rs == RS_IDLE) ? ar_err : rd_err;
  assign rd_enter_resp = (rs_nxt == RS_RESP) && (rs != RS_RESP);

  always_comb begin
    rd_word = mem[rd_sel_idx];
    if (w_fire && !wr_err && (wr_idx == rd_sel_idx)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) rd_word[8*i +: 8] = w_data[8*i +: 8];
      end
    end
  end

  // Read channel context and response registers, captured entering RS_RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx <= '0;
      rd_err <= 1'b0;
      rd_cnt <= '0;
      r_data <= '0;
      r_resp <= 2'b00;
    end else begin
      if (ar_fire) begin
        rd_idx <= ar_idx;
        rd_err <= ar_err;
        rd_cnt <= rd_load;
      end else if (rs == RS_WAIT && rd_cnt != '0) begin
        rd_cnt <= rd_cnt - CNT_W'(1);
      end
      if (rd_enter_resp) begin
        r_data <= rd_sel_err ? '0 : rd_word;
        r_resp <= rd_sel_err ? 2'b11 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_sram_slave.sv
// tb/tb_ysyx_22050019_axi_sram_slave.sv - scoreboard bench for the AXI SRAM slave
module tb_ysyx_22050019_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] aw_addr = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [31:0] ar_addr = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready = 1'b1;

  always #5 clk = ~clk;

  ysyx_22050019_axi_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(1024),
    .BASE_ADDR(32'h8000_0000), .RD_LAT(3), .WR_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  r_exp_t     exp_r[$];
  logic [1:0] exp_b[$];
  r_exp_t     mon_r;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: pop and compare on every completed B/R handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got resp %b expected no response", b_resp);
        end else begin
          check("b_resp", 64'(b_resp), 64'(exp_b.pop_front()));
        end
      end
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected: got data %h expected no response", r_data);
        end else begin
          mon_r = exp_r.pop_front();
          check("r_data", r_data, mon_r.data);
          check("r_resp", 64'(r_resp), 64'(mon_r.resp));
        end
      end
    end
  end

  task automatic aw_hs(input logic [31:0] a);
    int n = 0;
    aw_addr = a;
    aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && n < 100) begin n++; @(negedge clk); end
    if (!aw_ready) timeout_fail("aw_timeout");
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic w_hs(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    w_data = d;
    w_strb = s;
    w_valid = 1'b1;
    @(negedge clk);
    while (!w_ready && n < 100) begin n++; @(negedge clk); end
    if (!w_ready) timeout_fail("w_timeout");
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a);
    int n = 0;
    ar_addr = a;
    ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 100) begin n++; @(negedge clk); end
    if (!ar_ready) timeout_fail("ar_timeout");
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) timeout_fail("resp_timeout");
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [1:0] resp);
    exp_b.push_back(resp);
    aw_hs(a);
    w_hs(d, s);
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] resp);
    r_exp_t e;
    e.data = d;
    e.resp = resp;
    exp_r.push_back(e);
    ar_hs(a);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", 64'(aw_ready), 64'd1);
    check("rst_ar_ready", 64'(ar_ready), 64'd1);
    check("rst_w_ready",  64'(w_ready),  64'd0);
    check("rst_b_valid",  64'(b_valid),  64'd0);
    check("rst_r_valid",  64'(r_valid),  64'd0);
    check("rst_b_resp",   64'(b_resp),   64'd0);
    check("rst_r_resp",   64'(r_resp),   64'd0);
    check("rst_r_data",   r_data,        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: full word write and read back
    do_write(32'h8000_0010, 64'h1122334455667788, 8'hFF, 2'b00);
    do_read(32'h8000_0010, 64'h1122334455667788, 2'b00);

    // 2: partial strobe write with B backpressure
    b_ready = 1'b0;
    exp_b.push_back(2'b00);
    aw_hs(32'h8000_0010);
    w_hs(64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_valid_hold", 64'(b_valid), 64'd1);
      check("b_resp_hold", 64'(b_resp), 64'd0);
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    wait_idle();
    do_read(32'h8000_0010, 64'h11223344_BBBBBBBB, 2'b00);

    // 3: read latency and R backpressure
    r_ready = 1'b0;
    e.data = 64'h11223344_BBBBBBBB;
    e.resp = 2'b00;
    exp_r.push_back(e);
    ar_hs(32'h8000_0010);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("r_valid_early", 64'(r_valid), 64'd0);
    end
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      check("r_valid_held", 64'(r_valid), 64'd1);
      check("r_data_held", r_data, 64'h11223344_BBBBBBBB);
      check("ar_ready_busy", 64'(ar_ready), 64'd0);
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(negedge clk);
    check("ar_ready_at_hs", 64'(ar_ready), 64'd0);
    @(negedge clk);
    check("ar_ready_after", 64'(ar_ready), 64'd1);
    check("r_valid_after", 64'(r_valid), 64'd0);
    wait_idle();

    // 4: decode errors leave the array untouched
    do_write(32'h8000_0000, 64'hA0A1A2A3A4A5A6A7, 8'hFF, 2'b00);
    do_write(32'h8000_1FF8, 64'hB0B1B2B3B4B5B6B7, 8'hFF, 2'b00);
    do_read(32'h7FFF_FFF8, 64'd0, 2'b11);
    do_read(32'h8000_2000, 64'd0, 2'b11);
    do_write(32'h8000_2000, 64'hDEADBEEF_DEADBEEF, 8'hFF, 2'b11);
    do_write(32'h7FFF_FFF8, 64'hDEADBEEF_DEADBEEF, 8'hFF, 2'b11);
    do_read(32'h8000_0000, 64'hA0A1A2A3A4A5A6A7, 2'b00);
    do_read(32'h8000_1FF8, 64'hB0B1B2B3B4B5B6B7, 2'b00);

    // 5: write to index 4 lands on the edge the read enters its response
    do_write(32'h8000_0020, 64'h0102030405060708, 8'hFF, 2'b00);
    aw_hs(32'h8000_0024);
    exp_b.push_back(2'b00);
    e.data = 64'hFFEEDDCC_05060708;
    e.resp = 2'b00;
    exp_r.push_back(e);
    ar_hs(32'h8000_0020);
    repeat (2) @(posedge clk);
    #1;
    w_hs(64'hFFEEDDCC_BBAA9988, 8'hF0);
    wait_idle();
    do_read(32'h8000_0027, 64'hFFEEDDCC_05060708, 2'b00);

    // 6: reset mid-transaction, contents retained
    do_write(32'h8000_0030, 64'h0F1E2D3C4B5A6978, 8'hFF, 2'b00);
    r_ready = 1'b0;
    ar_hs(32'h8000_0030);
    repeat (5) @(posedge clk);
    #1;
    aw_hs(32'h8000_0038);
    w_hs(64'h5555666677778888, 8'hFF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_b_valid",  64'(b_valid),  64'd0);
    check("mid_rst_r_valid",  64'(r_valid),  64'd0);
    check("mid_rst_aw_ready", 64'(aw_ready), 64'd1);
    check("mid_rst_ar_ready", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    r_ready = 1'b1;
    do_read(32'h8000_0030, 64'h0F1E2D3C4B5A6978, 2'b00);
    do_read(32'h8000_0038, 64'h5555666677778888, 2'b00);
    do_read(32'h8000_0010, 64'h11223344_BBBBBBBB, 2'b00);

    wait_idle();
    check("queues_drained", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
